// File: rtl/johnson_phase_sequencer_pkg.sv
// Thermometer-code helpers shared by the Johnson phase sequencer.
// Codes are held in a fixed 16-bit container; callers truncate to NUM_PHASES.
package johnson_seq_pkg;

  localparam int MAX_PHASES = 16;

  typedef logic [MAX_PHASES-1:0] therm_t;

  function automatic therm_t therm_code(input int k, input int width);
    therm_t c;
    c = '0;
    for (int i = 0; i < MAX_PHASES; i++) begin
      if ((i < k) && (i < width)) c[i] = 1'b1;
    end
    return c;
  endfunction

  // A zero-extended code is a legal thermometer exactly when it is 2^k - 1.
  function automatic logic is_legal_therm(input therm_t code);
    return (code & (code + therm_t'(1))) == '0;
  endfunction

  function automatic therm_t therm_to_onehot(input therm_t code);
    return code ^ (code >> 1);
  endfunction

endpackage

// File: rtl/johnson_phase_sequencer_dwell_counter.sv
// Dwell counter: clear beats load beats decrement; o_zero flags an expired dwell.
module seq_dwell_counter
  import johnson_seq_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               i_clr,
  input  logic               i_load,
  input  logic               i_dec,
  input  logic [DWELL_W-1:0] i_loadVal,
  output logic               o_zero
);

  logic [DWELL_W-1:0] r_count;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - DWELL_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/johnson_phase_sequencer.sv
// Parametrised thermometer-coded phase sequencer with programmable dwell,
// one-shot/loop modes, synchronous abort and illegal-code recovery.
module johnson_phase_sequencer
  import johnson_seq_pkg::*;
#(
  parameter int NUM_PHASES = 3,
  parameter int DWELL_W    = 8
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [NUM_PHASES-1:0] phase_o,
  output logic                  busy,
  output logic                  wrap_o,
  output logic                  done_o,
  output logic                  state_err
);

  localparam logic [NUM_PHASES-1:0] IDLE   = '0;
  localparam logic [NUM_PHASES-1:0] PHASE1 = NUM_PHASES'(therm_code(1, NUM_PHASES));
  localparam logic [NUM_PHASES-1:0] LAST   = NUM_PHASES'(therm_code(NUM_PHASES, NUM_PHASES));

  logic [NUM_PHASES-1:0] r_state;
  logic [DWELL_W-1:0]    r_dwellQ;
  logic                  r_wrap;
  logic                  r_done;
  logic                  r_err;

  logic [NUM_PHASES-1:0] w_nextState;
  logic                  w_legal;
  logic                  w_zero;
  logic                  w_clr;
  logic                  w_load;
  logic                  w_dec;
  logic                  w_loadFromInput;
  logic [DWELL_W-1:0]    w_loadVal;
  logic                  w_accept;
  logic                  w_wrapSet;
  logic                  w_doneSet;
  logic                  w_errSet;

  assign w_legal   = is_legal_therm(therm_t'(r_state));
  assign w_loadVal = w_loadFromInput ? dwell : r_dwellQ;

  seq_dwell_counter #(.DWELL_W(DWELL_W)) u_dwellCounter (
    .clk       (clk),
    .rstN      (rstN),
    .i_clr     (w_clr),
    .i_load    (w_load),
    .i_dec     (w_dec),
    .i_loadVal (w_loadVal),
    .o_zero    (w_zero)
  );

  // Every reachable branch assigns the next state, so the X default never escapes.
  always_comb begin
    w_nextState     = 'x;
    w_clr           = 1'b0;
    w_load          = 1'b0;
    w_dec           = 1'b0;
    w_loadFromInput = 1'b0;
    w_accept        = 1'b0;
    w_wrapSet       = 1'b0;
    w_doneSet       = 1'b0;
    w_errSet        = 1'b0;
    if (stop) begin
      w_nextState = IDLE;
      w_clr       = 1'b1;
    end else if (!w_legal) begin
      w_nextState = IDLE;
      w_clr       = 1'b1;
      w_errSet    = 1'b1;
    end else if (r_state == IDLE) begin
      if (start) begin
        w_nextState     = PHASE1;
        w_load          = 1'b1;
        w_loadFromInput = 1'b1;
        w_accept        = 1'b1;
      end else begin
        w_nextState = IDLE;
      end
    end else if (!w_zero) begin
      w_nextState = r_state;
      w_dec       = 1'b1;
    end else if (r_state != LAST) begin
      w_nextState = {r_state[NUM_PHASES-2:0], 1'b1};
      w_load      = 1'b1;
    end else if (loop_en) begin
      w_nextState = PHASE1;
      w_load      = 1'b1;
      w_wrapSet   = 1'b1;
    end else begin
      w_nextState = IDLE;
      w_doneSet   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state  <= IDLE;
      r_dwellQ <= '0;
      r_wrap   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_wrap  <= w_wrapSet;
      r_done  <= w_doneSet;
      if (w_accept) r_dwellQ <= dwell;
      if (w_errSet) begin
        r_err <= 1'b1;
      end else if (w_accept) begin
        r_err <= 1'b0;
      end
    end
  end

  // Illegal codes decode to no strobe and not busy until the recovery edge.
  always_comb begin
    phase_o = '0;
    busy    = 1'b0;
    if (w_legal && (r_state != IDLE)) begin
      phase_o = NUM_PHASES'(therm_to_onehot(therm_t'(r_state)));
      busy    = 1'b1;
    end
  end

  assign wrap_o    = r_wrap;
  assign done_o    = r_done;
  assign state_err = r_err;

endmodule

// File: doc/johnson_phase_sequencer.md
# johnson_phase_sequencer

- Parametrised successor to the team's fixed 3-phase READY/SET/GO sequencer.
- Steps through NUM_PHASES phases using a thermometer (Johnson-style) state code, holding each phase for a programmable dwell time.
- Runs either one-shot or continuous loop, supports synchronous abort, and detects and recovers from illegal state codes.
- Sits between a control register block and datapath phase enables; drives one-hot phase strobes.

## Interface
Parameters:
- NUM_PHASES, 3, number of active phases (2..16); also the state register width.
- DWELL_W, 8, width of the dwell counter and the dwell input.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- rstN  input  1  reset, asynchronous, active-low.
- start  input  1  begin a sequence; honoured only in IDLE.
- stop  input  1  synchronous abort; honoured in any state.
- loop_en  input  1  sampled at the end of the last phase: 1 wraps to phase 1, 0 returns to IDLE.
- dwell  input  DWELL_W  extra cycles per phase; latched on an accepted start.
- phase_o  output  NUM_PHASES  one-hot phase strobe; bit k-1 is high in phase k; all zero in IDLE.
- busy  output  1  high in any phase state.
- wrap_o  output  1  one-cycle pulse on re-entry to phase 1 via loop.
- done_o  output  1  one-cycle pulse on normal completion (not on abort).
- state_err  output  1  sticky illegal-state flag.

## Operation
State encoding:
- IDLE = all zeros.
- Phase k (1..NUM_PHASES) = k low bits set. Example for 3 phases: 001, 011, 111.
- Any other code is illegal.

Next-state decoder:
- Pre-assigns X before decoding.
- Every legal code is then decoded explicitly.
- The illegal-code branch assigns IDLE explicitly, so recovery is deterministic. It does not rely on the X.

Transitions, in priority order:
1. stop: next state is IDLE from any state. Dwell counter clears. No done_o.
2. Illegal code: next state is IDLE and state_err is set.
3. IDLE with start: latch dwell into dwell_q, load the counter with dwell, go to phase 1.
4. Phase k with counter ≠ 0: hold the phase and decrement the counter.
5. Phase k with counter == 0, k < NUM_PHASES: go to phase k+1 and reload the counter from dwell_q.
6. Last phase with counter == 0:
   - loop_en = 1: go to phase 1, reload the counter, assert wrap_o.
   - loop_en = 0: go to IDLE, assert done_o.

Other rules:
- start is ignored while busy. dwell_q changes only on an accepted start.
- state_err clears on reset or on an accepted start. It is never cleared by stop.
- Counter arithmetic is unsigned, DWELL_W bits. It never underflows because the counter only decrements when ≠ 0.

## Timing
- phase_o and busy are decoded combinationally from the state register.
- wrap_o, done_o and state_err are registered and coincide with the state they describe:
  - done_o is high in the first IDLE cycle.
  - wrap_o is high in the first phase-1 cycle of the new pass.
- Latency: start sampled at edge N gives phase_o = 1 (one-hot bit 0) from edge N+1.
- Each phase lasts dwell+1 cycles. One full pass is NUM_PHASES·(dwell+1) cycles.
- Back-to-back: start in the same cycle that done_o is high is accepted, because that is an IDLE cycle.
- stop and start together in IDLE: stop wins and the state stays IDLE.
- stop on the final counter cycle of the last phase: go to IDLE with no done_o and no wrap_o.
- Reset values, asynchronous on rstN low:
  - state = IDLE, counter = 0, dwell_q = 0.
  - phase_o = 0, busy = 0, wrap_o = 0, done_o = 0, state_err = 0.
- Reset mid-sequence takes effect immediately, with no pulse emitted.

## Structure
Package johnson_seq_pkg contains:
- Function therm_code(k, width) returning the phase-k code.
- Function is_legal_therm(code).
- Function therm_to_onehot(code).
- The state is a parametrised logic vector, not an enum, because its width depends on NUM_PHASES.

Sub-module seq_dwell_counter (DWELL_W): synchronous load, decrement, clear, and zero flag.

The top level holds the state register, the next-state decoder with pre-case X assignment, the output decoder with pre-case '0 default, and the pulse and error flops.

## Test plan
All scenarios use NUM_PHASES=3, DWELL_W=8.
- One-shot, dwell=0, loop_en=0, start pulse:
  - phase_o is 001, 010, 100 on cycles 1–3.
  - done_o is high on cycle 4 with busy=0.
  - 3 phases × 1 cycle.
- Loop, dwell=2, loop_en=1:
  - Each phase_o bit is high for 3 cycles.
  - wrap_o pulses on cycle 10.
  - Drop loop_en during pass 2: done_o on cycle 19, no second wrap_o.
- Abort: stop asserted in phase 2 mid-dwell:
  - phase_o = 000 next cycle.
  - No done_o.
  - A new start with dwell=5 gives 6 cycles per phase.
- Collisions:
  - start while busy is ignored, and dwell_q is unchanged.
  - stop+start in IDLE stays in IDLE.
  - start on the done_o cycle re-enters phase 1 next cycle.
- Illegal code: force state = 3'b101 for one cycle:
  - Next cycle is IDLE and state_err = 1, which persists through stop.
  - state_err clears on the next accepted start.
- Async reset mid-phase-3 with dwell=4:
  - All outputs are 0 immediately.
  - After release, the block stays IDLE until start.
